ledm_scan_ctrl: RTL

//   Time-multiplexed scan controller for the board's 5-column x 8-row LED matrix.

---
 rtl/ledm_scan_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ledm_scan_ctrl.sv
// Column-scan controller for a 5x8 LED matrix: double-buffered frame store,
// blanking dead time between columns and 16-level brightness gating per dwell.
module ledm_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          COL_ACTIVE_LOW = 1'b1,
    parameter bit          ROW_ACTIVE_LOW = 1'b0
) (
    input  logic       CLOCK_50MHz,
    input  logic       RESET,
    input  logic       WR_EN,
    input  logic [2:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       SWAP_REQ,
    output logic       SWAP_ACK,
    input  logic [3:0] BRIGHT,
    output logic       FRAME_START,
    output logic [4:0] LEDM_C,
    output logic [7:0] LEDM_R
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_FULL = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0] BRIGHT_STEP = CW'(DWELL_CYCLES / 16);

    localparam logic [4:0] COL_OFF = COL_ACTIVE_LOW ? 5'b11111 : 5'b00000;
    localparam logic [7:0] ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      col, col_nx;
    logic [CW-1:0]   timer, timer_nx;
    logic [3:0]      bright_q, bright_nx;
    logic [4:0][7:0] buf0, buf1;
    logic            front_sel, front_sel_nx;
    logic            swap_pend, swap_pend_nx;
    logic            frame_edge, do_swap;
    logic [CW-1:0]   on_lim;
    logic [7:0]      front_col;
    logic            row_on;
    logic [4:0]      col_pins_nx;
    logic [7:0]      row_pins_nx;

    always_comb begin
        state_nx   = state;
        col_nx     = col;
        timer_nx   = timer + 1'b1;
        bright_nx  = bright_q;
        frame_edge = 1'b0;
        case (state)
            ST_BLANK: begin
                if (timer == BLANK_LAST) begin
                    state_nx  = ST_DRIVE;
                    timer_nx  = '0;
                    bright_nx = BRIGHT;
                end
            end
            ST_DRIVE: begin
                if (timer == DWELL_LAST) begin
                    state_nx = ST_BLANK;
                    timer_nx = '0;
                    if (col == 3'd4) begin
                        col_nx     = '0;
                        frame_edge = 1'b1;
                    end else begin
                        col_nx = col + 3'd1;
                    end
                end
            end
        endcase
    end

    // Swaps only happen at the frame boundary, so a whole frame always comes
    // from one buffer; a request on the boundary clock carries into next frame.
    always_comb begin
        do_swap      = frame_edge & swap_pend;
        swap_pend_nx = SWAP_REQ | (swap_pend & ~do_swap);
        front_sel_nx = front_sel ^ do_swap;
    end

    // Pins are registered from next-state values so they change on the same
    // edge that enters a state. Front data read here is never swapped on a
    // BLANK->DRIVE edge, so the current buffer select is the right one.
    always_comb begin
        on_lim      = (bright_nx == 4'hF) ? DWELL_FULL : CW'(bright_nx) * BRIGHT_STEP;
        front_col   = front_sel ? buf1[col_nx] : buf0[col_nx];
        row_on      = (state_nx == ST_DRIVE) && (timer_nx < on_lim);
        col_pins_nx = COL_OFF;
        row_pins_nx = ROW_OFF;
        if (state_nx == ST_DRIVE) begin
            col_pins_nx = COL_OFF ^ (5'b00001 << col_nx);
        end
        if (row_on) begin
            row_pins_nx = ROW_OFF ^ front_col;
        end
    end

    always_ff @(posedge CLOCK_50MHz) begin
        if (RESET) begin
            state       <= ST_BLANK;
            col         <= '0;
            timer       <= '0;
            bright_q    <= '0;
            front_sel   <= 1'b0;
            swap_pend   <= 1'b0;
            SWAP_ACK    <= 1'b0;
            FRAME_START <= 1'b0;
            LEDM_C      <= COL_OFF;
            LEDM_R      <= ROW_OFF;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            timer       <= timer_nx;
            bright_q    <= bright_nx;
            front_sel   <= front_sel_nx;
            swap_pend   <= swap_pend_nx;
            SWAP_ACK    <= do_swap;
            FRAME_START <= frame_edge;
            LEDM_C      <= col_pins_nx;
            LEDM_R      <= row_pins_nx;
        end
    end

    // Writes target the buffer that is back before this edge's swap.
    always_ff @(posedge CLOCK_50MHz) begin
        if (RESET) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (WR_EN && (WR_ADDR < 3'd5)) begin
            if (front_sel) begin
                buf0[WR_ADDR] <= WR_DATA;
            end else begin
                buf1[WR_ADDR] <= WR_DATA;
            end
        end
    end

endmodule
